l2_port_arbiter: RTL and testbench

- Shares one L2 memory port between the three L1 cache channels: instruction-cache read, data-cache read and data-cache write.
- Sits between the RISCV_PROCESSOR L2-side ports and the L2 memory (or its bench emulator).
- Serialises requests with at most one transaction outstanding, and routes the response back to the requester that issued it.

---
 rtl/l2_port_arbiter_if.sv | 61 ++++++
 rtl/l2_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_l2_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_port_arbiter_if.sv
// L1-side and memory-side signal bundle for l2_port_arbiter.
// master = the arbiter itself; slave = the caches and L2 memory around it.
interface l2_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32
);
  localparam int AW = ADDRESS_WIDTH - 2;

  logic                    ADDRESS_TO_L2_VALID_INS;
  logic                    ADDRESS_TO_L2_READY_INS;
  logic [AW-1:0]           ADDRESS_TO_L2_INS;
  logic                    DATA_FROM_L2_VALID_INS;
  logic                    DATA_FROM_L2_READY_INS;
  logic [L2_BUS_WIDTH-1:0] DATA_FROM_L2_INS;

  logic                    READ_ADDR_TO_L2_VALID_DATA;
  logic                    READ_ADDR_TO_L2_READY_DATA;
  logic [AW-1:0]           READ_ADDR_TO_L2_DATA;
  logic                    DATA_FROM_L2_VALID_DATA;
  logic                    DATA_FROM_L2_READY_DATA;
  logic [L2_BUS_WIDTH-1:0] DATA_FROM_L2_DATA;

  logic                    WRITE_TO_L2_VALID_DATA;
  logic                    WRITE_TO_L2_READY_DATA;
  logic [AW-1:0]           WRITE_ADDR_TO_L2_DATA;
  logic [L2_BUS_WIDTH-1:0] DATA_TO_L2_DATA;
  logic                    WRITE_CONTROL_TO_L2_DATA;
  logic                    WRITE_COMPLETE_DATA;

  logic                    MEM_REQ_VALID;
  logic                    MEM_REQ_READY;
  logic                    MEM_REQ_WRITE;
  logic [AW-1:0]           MEM_REQ_ADDR;
  logic [L2_BUS_WIDTH-1:0] MEM_REQ_WDATA;
  logic                    MEM_RESP_VALID;
  logic [L2_BUS_WIDTH-1:0] MEM_RESP_DATA;

  modport master (
    input  ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS,
    output ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
    input  READ_ADDR_TO_L2_VALID_DATA, READ_ADDR_TO_L2_DATA, DATA_FROM_L2_READY_DATA,
    output READ_ADDR_TO_L2_READY_DATA, DATA_FROM_L2_VALID_DATA, DATA_FROM_L2_DATA,
    input  WRITE_TO_L2_VALID_DATA, WRITE_ADDR_TO_L2_DATA, DATA_TO_L2_DATA,
    input  WRITE_CONTROL_TO_L2_DATA,
    output WRITE_TO_L2_READY_DATA, WRITE_COMPLETE_DATA,
    output MEM_REQ_VALID, MEM_REQ_WRITE, MEM_REQ_ADDR, MEM_REQ_WDATA,
    input  MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA
  );

  modport slave (
    output ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_INS, DATA_FROM_L2_READY_INS,
    input  ADDRESS_TO_L2_READY_INS, DATA_FROM_L2_VALID_INS, DATA_FROM_L2_INS,
    output READ_ADDR_TO_L2_VALID_DATA, READ_ADDR_TO_L2_DATA, DATA_FROM_L2_READY_DATA,
    input  READ_ADDR_TO_L2_READY_DATA, DATA_FROM_L2_VALID_DATA, DATA_FROM_L2_DATA,
    output WRITE_TO_L2_VALID_DATA, WRITE_ADDR_TO_L2_DATA, DATA_TO_L2_DATA,
    output WRITE_CONTROL_TO_L2_DATA,
    input  WRITE_TO_L2_READY_DATA, WRITE_COMPLETE_DATA,
    input  MEM_REQ_VALID, MEM_REQ_WRITE, MEM_REQ_ADDR, MEM_REQ_WDATA,
    output MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_DATA
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between I-read, D-read and D-write, one transaction at a time.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin grant instead of fixed priority.
module l2_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32
) (
  input logic                CLK,
  input logic                RESET_N,
  l2_port_arbiter_if.master  bus
);
  localparam int AW = ADDRESS_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;
  typedef enum logic [1:0] {OWN_DWR = 2'd0, OWN_DRD = 2'd1, OWN_INS = 2'd2} owner_t;

  state_t                  state_q;
  owner_t                  owner_q;
  logic [AW-1:0]           addr_q;
  logic [L2_BUS_WIDTH-1:0] wdata_q;
  logic                    wr_q;
  logic                    req_vld_q;
  logic                    wc_q;
  logic                    ins_vld_q;
  logic                    drd_vld_q;
  logic [L2_BUS_WIDTH-1:0] ins_data_q;
  logic [L2_BUS_WIDTH-1:0] drd_data_q;

  logic [2:0]              req;
  logic                    grant_vld;
  owner_t                  grant_own;
  logic [AW-1:0]           grant_addr;
  logic                    accept;

  // Request vector indexed by owner code.
  assign req = {bus.ADDRESS_TO_L2_VALID_INS, bus.READ_ADDR_TO_L2_VALID_DATA,
                bus.WRITE_TO_L2_VALID_DATA};

`ifdef L2_ARB_ROUND_ROBIN_EN
  owner_t     last_q;
  logic [1:0] cand;

  // Search starts one past the last grant and wraps DWR -> DRD -> INS.
  always_comb begin
    grant_vld = 1'b0;
    grant_own = OWN_DWR;
    cand      = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(last_q) + k) % 3);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_own = owner_t'(cand);
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b1;
    grant_own = OWN_DWR;
    if (req[0])      grant_own = OWN_DWR;
    else if (req[1]) grant_own = OWN_DRD;
    else if (req[2]) grant_own = OWN_INS;
    else             grant_vld = 1'b0;
  end
`endif

  always_comb begin
    grant_addr = bus.ADDRESS_TO_L2_INS;
    case (grant_own)
      OWN_DWR: grant_addr = bus.WRITE_ADDR_TO_L2_DATA;
      OWN_DRD: grant_addr = bus.READ_ADDR_TO_L2_DATA;
      default: grant_addr = bus.ADDRESS_TO_L2_INS;
    endcase
  end

  assign accept = RESET_N && (state_q == S_IDLE) && grant_vld;

  assign bus.WRITE_TO_L2_READY_DATA     = accept && (grant_own == OWN_DWR);
  assign bus.READ_ADDR_TO_L2_READY_DATA = accept && (grant_own == OWN_DRD);
  assign bus.ADDRESS_TO_L2_READY_INS    = accept && (grant_own == OWN_INS);

  assign bus.MEM_REQ_VALID           = req_vld_q;
  assign bus.MEM_REQ_WRITE           = wr_q;
  assign bus.MEM_REQ_ADDR            = addr_q;
  assign bus.MEM_REQ_WDATA           = wdata_q;
  assign bus.WRITE_COMPLETE_DATA     = wc_q;
  assign bus.DATA_FROM_L2_VALID_INS  = ins_vld_q;
  assign bus.DATA_FROM_L2_INS        = ins_data_q;
  assign bus.DATA_FROM_L2_VALID_DATA = drd_vld_q;
  assign bus.DATA_FROM_L2_DATA       = drd_data_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_DWR;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      req_vld_q  <= 1'b0;
      wc_q       <= 1'b0;
      ins_vld_q  <= 1'b0;
      drd_vld_q  <= 1'b0;
      ins_data_q <= '0;
      drd_data_q <= '0;
`ifdef L2_ARB_ROUND_ROBIN_EN
      last_q     <= OWN_INS;
`endif
    end else begin
      wc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            owner_q   <= grant_own;
            addr_q    <= grant_addr;
            wdata_q   <= (grant_own == OWN_DWR) ? bus.DATA_TO_L2_DATA : '0;
            wr_q      <= (grant_own == OWN_DWR) && bus.WRITE_CONTROL_TO_L2_DATA;
            req_vld_q <= 1'b1;
            state_q   <= S_ISSUE;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_q    <= grant_own;
`endif
          end
        end
        S_ISSUE: begin
          if (bus.MEM_REQ_READY) begin
            req_vld_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.MEM_RESP_VALID) begin
            if (owner_q == OWN_DWR) begin
              wc_q    <= 1'b1;
              state_q <= S_IDLE;
            end else if (owner_q == OWN_DRD) begin
              drd_data_q <= bus.MEM_RESP_DATA;
              drd_vld_q  <= 1'b1;
              state_q    <= S_RETURN;
            end else begin
              ins_data_q <= bus.MEM_RESP_DATA;
              ins_vld_q  <= 1'b1;
              state_q    <= S_RETURN;
            end
          end
        end
        S_RETURN: begin
          if ((owner_q == OWN_DRD && bus.DATA_FROM_L2_READY_DATA) ||
              (owner_q == OWN_INS && bus.DATA_FROM_L2_READY_INS)) begin
            drd_vld_q <= 1'b0;
            ins_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a small in-bench L2 memory emulator.
module tb_l2_port_arbiter;
  logic CLK;
  logic RESET_N;
  int   n_tests;
  int   n_fail;
  logic [31:0] mem [0:127];
  int   exp_seq [4];

  l2_port_arbiter_if #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) bus ();

  l2_port_arbiter #(.ADDRESS_WIDTH(32), .L2_BUS_WIDTH(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk30(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    bus.ADDRESS_TO_L2_VALID_INS    = 1'b0;
    bus.ADDRESS_TO_L2_INS          = '0;
    bus.DATA_FROM_L2_READY_INS     = 1'b1;
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    bus.READ_ADDR_TO_L2_DATA       = '0;
    bus.DATA_FROM_L2_READY_DATA    = 1'b1;
    bus.WRITE_TO_L2_VALID_DATA     = 1'b0;
    bus.WRITE_ADDR_TO_L2_DATA      = '0;
    bus.DATA_TO_L2_DATA            = '0;
    bus.WRITE_CONTROL_TO_L2_DATA   = 1'b0;
    bus.MEM_REQ_READY              = 1'b1;
    bus.MEM_RESP_VALID             = 1'b0;
    bus.MEM_RESP_DATA              = '0;
    step();
    step();
    RESET_N = 1'b1;
  endtask

  // Entered in the ISSUE cycle with MEM_REQ_READY high; returns in the cycle after the response.
  task automatic issue_and_respond(input string tag, input logic [29:0] a,
                                   input logic w, input logic [31:0] wd);
    chk1({tag, "_req_vld"}, bus.MEM_REQ_VALID, 1'b1);
    chk30({tag, "_req_addr"}, bus.MEM_REQ_ADDR, a);
    chk1({tag, "_req_wr"}, bus.MEM_REQ_WRITE, w);
    if (w) chk32({tag, "_req_wdata"}, bus.MEM_REQ_WDATA, wd);
    if (bus.MEM_REQ_VALID && bus.MEM_REQ_WRITE) mem[bus.MEM_REQ_ADDR[6:0]] = bus.MEM_REQ_WDATA;
    step();
    chk1({tag, "_req_drop"}, bus.MEM_REQ_VALID, 1'b0);
    bus.MEM_RESP_VALID = 1'b1;
    bus.MEM_RESP_DATA  = mem[bus.MEM_REQ_ADDR[6:0]];
    step();
    bus.MEM_RESP_VALID = 1'b0;
    bus.MEM_RESP_DATA  = '0;
  endtask

  task automatic rr_txn(input string tag, input int own);
    chk1({tag, "_rdy_wr"}, bus.WRITE_TO_L2_READY_DATA, own == 0);
    chk1({tag, "_rdy_rd"}, bus.READ_ADDR_TO_L2_READY_DATA, own == 1);
    chk1({tag, "_rdy_ins"}, bus.ADDRESS_TO_L2_READY_INS, own == 2);
    step();
    issue_and_respond(tag, 30'(32'h50 + own), own == 0, 32'hC0FFEE00);
    if (own == 0) begin
      chk1({tag, "_wc"}, bus.WRITE_COMPLETE_DATA, 1'b1);
    end else begin
      chk1({tag, "_rvld"}, (own == 1) ? bus.DATA_FROM_L2_VALID_DATA : bus.DATA_FROM_L2_VALID_INS, 1'b1);
      step();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[7'h05] = 32'h00500093;
    mem[7'h21] = 32'hA5A5A5A5;
    mem[7'h22] = 32'h0BADF00D;
    mem[7'h30] = 32'h13572468;
    mem[7'h31] = 32'h24680ACE;
    mem[7'h51] = 32'h51515151;
    mem[7'h52] = 32'h52525252;
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 0;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif

    // Reset state
    do_reset();
    chk1("rst_req_vld", bus.MEM_REQ_VALID, 1'b0);
    chk1("rst_req_wr", bus.MEM_REQ_WRITE, 1'b0);
    chk30("rst_req_addr", bus.MEM_REQ_ADDR, 30'h0);
    chk32("rst_req_wdata", bus.MEM_REQ_WDATA, 32'h0);
    chk1("rst_wc", bus.WRITE_COMPLETE_DATA, 1'b0);
    chk1("rst_vld_ins", bus.DATA_FROM_L2_VALID_INS, 1'b0);
    chk1("rst_vld_data", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    chk1("rst_rdy_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b0);

    // Single instruction read: accept c0, request c1, response c2, data c3
    bus.ADDRESS_TO_L2_VALID_INS = 1'b1;
    bus.ADDRESS_TO_L2_INS       = 30'h5;
    #1;
    chk1("t1_rdy_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b1);
    chk1("t1_rdy_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b0);
    chk1("t1_req_c0", bus.MEM_REQ_VALID, 1'b0);
    step();
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    issue_and_respond("t1", 30'h5, 1'b0, 32'h0);
    chk1("t1_vld_ins", bus.DATA_FROM_L2_VALID_INS, 1'b1);
    chk32("t1_data_ins", bus.DATA_FROM_L2_INS, 32'h00500093);
    chk1("t1_vld_data", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    step();
    chk1("t1_vld_ins_drop", bus.DATA_FROM_L2_VALID_INS, 1'b0);

    // Write then read back
    bus.WRITE_TO_L2_VALID_DATA   = 1'b1;
    bus.WRITE_ADDR_TO_L2_DATA    = 30'h10;
    bus.DATA_TO_L2_DATA          = 32'hDEADBEEF;
    bus.WRITE_CONTROL_TO_L2_DATA = 1'b1;
    #1;
    chk1("t2_rdy_wr", bus.WRITE_TO_L2_READY_DATA, 1'b1);
    step();
    bus.WRITE_TO_L2_VALID_DATA = 1'b0;
    issue_and_respond("t2w", 30'h10, 1'b1, 32'hDEADBEEF);
    chk1("t2_wc_pulse", bus.WRITE_COMPLETE_DATA, 1'b1);
    step();
    chk1("t2_wc_single", bus.WRITE_COMPLETE_DATA, 1'b0);
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    bus.READ_ADDR_TO_L2_DATA       = 30'h10;
    #1;
    chk1("t2_rdy_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b1);
    step();
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    issue_and_respond("t2r", 30'h10, 1'b0, 32'h0);
    chk1("t2_vld_data", bus.DATA_FROM_L2_VALID_DATA, 1'b1);
    chk32("t2_data", bus.DATA_FROM_L2_DATA, 32'hDEADBEEF);
    step();

    // No-op write (control 0) is still issued as non-write and acknowledged
    bus.WRITE_TO_L2_VALID_DATA   = 1'b1;
    bus.WRITE_ADDR_TO_L2_DATA    = 30'h11;
    bus.WRITE_CONTROL_TO_L2_DATA = 1'b0;
    step();
    bus.WRITE_TO_L2_VALID_DATA = 1'b0;
    issue_and_respond("t2n", 30'h11, 1'b0, 32'h0);
    chk1("t2n_wc", bus.WRITE_COMPLETE_DATA, 1'b1);
    chk1("t2n_no_rvld", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    step();

    // Simultaneous requests after reset: DWR, then DRD, then INS
    do_reset();
    bus.WRITE_TO_L2_VALID_DATA     = 1'b1;
    bus.WRITE_ADDR_TO_L2_DATA      = 30'h20;
    bus.DATA_TO_L2_DATA            = 32'h11112222;
    bus.WRITE_CONTROL_TO_L2_DATA   = 1'b1;
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    bus.READ_ADDR_TO_L2_DATA       = 30'h21;
    bus.ADDRESS_TO_L2_VALID_INS    = 1'b1;
    bus.ADDRESS_TO_L2_INS          = 30'h22;
    #1;
    chk1("t3_g1_wr", bus.WRITE_TO_L2_READY_DATA, 1'b1);
    chk1("t3_g1_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b0);
    chk1("t3_g1_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
    step();
    bus.WRITE_TO_L2_VALID_DATA = 1'b0;
    chk1("t3_busy_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b0);
    chk1("t3_busy_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
    issue_and_respond("t3w", 30'h20, 1'b1, 32'h11112222);
    chk1("t3_wc", bus.WRITE_COMPLETE_DATA, 1'b1);
    chk1("t3_g2_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b1);
    chk1("t3_g2_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
    step();
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    issue_and_respond("t3r", 30'h21, 1'b0, 32'h0);
    chk1("t3_vld_data", bus.DATA_FROM_L2_VALID_DATA, 1'b1);
    chk32("t3_data", bus.DATA_FROM_L2_DATA, 32'hA5A5A5A5);
    chk1("t3_ret_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
    step();
    chk1("t3_g3_ins", bus.ADDRESS_TO_L2_READY_INS, 1'b1);
    step();
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    issue_and_respond("t3i", 30'h22, 1'b0, 32'h0);
    chk1("t3_vld_ins", bus.DATA_FROM_L2_VALID_INS, 1'b1);
    chk32("t3_data_ins", bus.DATA_FROM_L2_INS, 32'h0BADF00D);
    step();

    // Backpressure on request and on returned data
    bus.MEM_REQ_READY              = 1'b0;
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    bus.READ_ADDR_TO_L2_DATA       = 30'h30;
    #1;
    chk1("t4_rdy_rd", bus.READ_ADDR_TO_L2_READY_DATA, 1'b1);
    step();
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    bus.ADDRESS_TO_L2_VALID_INS    = 1'b1;
    bus.ADDRESS_TO_L2_INS          = 30'h31;
    for (int i = 0; i < 5; i++) begin
      chk1("t4_hold_vld", bus.MEM_REQ_VALID, 1'b1);
      chk30("t4_hold_addr", bus.MEM_REQ_ADDR, 30'h30);
      chk1("t4_hold_wr", bus.MEM_REQ_WRITE, 1'b0);
      chk1("t4_no_grant", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
      step();
    end
    bus.MEM_REQ_READY           = 1'b1;
    bus.DATA_FROM_L2_READY_DATA = 1'b0;
    issue_and_respond("t4", 30'h30, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk1("t4_rvld_hold", bus.DATA_FROM_L2_VALID_DATA, 1'b1);
      chk32("t4_rdata_hold", bus.DATA_FROM_L2_DATA, 32'h13572468);
      chk1("t4_ret_no_grant", bus.ADDRESS_TO_L2_READY_INS, 1'b0);
      chk1("t4_ins_vld", bus.DATA_FROM_L2_VALID_INS, 1'b0);
      step();
    end
    bus.DATA_FROM_L2_READY_DATA = 1'b1;
    chk1("t4_rvld_last", bus.DATA_FROM_L2_VALID_DATA, 1'b1);
    step();
    chk1("t4_rvld_drop", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    chk1("t4_next_grant", bus.ADDRESS_TO_L2_READY_INS, 1'b1);
    step();
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    issue_and_respond("t4i", 30'h31, 1'b0, 32'h0);
    chk32("t4_data_ins", bus.DATA_FROM_L2_INS, 32'h24680ACE);
    step();

    // Reset while a read waits for its response; stray response afterwards
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    bus.READ_ADDR_TO_L2_DATA       = 30'h40;
    step();
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b0;
    step();
    chk1("t5_in_wait", bus.MEM_REQ_VALID, 1'b0);
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    chk1("t5_req_vld", bus.MEM_REQ_VALID, 1'b0);
    chk30("t5_req_addr", bus.MEM_REQ_ADDR, 30'h0);
    chk1("t5_vld_data", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    chk32("t5_data", bus.DATA_FROM_L2_DATA, 32'h0);
    chk32("t5_data_ins", bus.DATA_FROM_L2_INS, 32'h0);
    bus.MEM_RESP_VALID = 1'b1;
    bus.MEM_RESP_DATA  = 32'hFFFFFFFF;
    step();
    bus.MEM_RESP_VALID = 1'b0;
    bus.MEM_RESP_DATA  = '0;
    chk1("t5_stray_vld", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    chk32("t5_stray_data", bus.DATA_FROM_L2_DATA, 32'h0);
    chk1("t5_stray_wc", bus.WRITE_COMPLETE_DATA, 1'b0);
    step();
    chk1("t5_still_quiet", bus.DATA_FROM_L2_VALID_DATA, 1'b0);
    bus.ADDRESS_TO_L2_VALID_INS = 1'b1;
    #1;
    chk1("t5_idle", bus.ADDRESS_TO_L2_READY_INS, 1'b1);
    bus.ADDRESS_TO_L2_VALID_INS = 1'b0;
    step();

    // All three requesters asserting continuously from reset
    do_reset();
    bus.WRITE_TO_L2_VALID_DATA     = 1'b1;
    bus.WRITE_ADDR_TO_L2_DATA      = 30'h50;
    bus.DATA_TO_L2_DATA            = 32'hC0FFEE00;
    bus.WRITE_CONTROL_TO_L2_DATA   = 1'b1;
    bus.READ_ADDR_TO_L2_VALID_DATA = 1'b1;
    bus.READ_ADDR_TO_L2_DATA       = 30'h51;
    bus.ADDRESS_TO_L2_VALID_INS    = 1'b1;
    bus.ADDRESS_TO_L2_INS          = 30'h52;
    #1;
    rr_txn("t6_g0", exp_seq[0]);
    rr_txn("t6_g1", exp_seq[1]);
    rr_txn("t6_g2", exp_seq[2]);
    rr_txn("t6_g3", exp_seq[3]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
